// File: rtl/fme_fir_pkg.sv
// Shared constants for the half-pel 6-tap FIR: taps, rounding, latency and width helpers.
// The optional full-precision output is enabled by the macro FME_FIR_FULLPREC_EN.
package fme_fir_pkg;

    // Symmetric taps (1,-5,20,20,-5,1); only the first half is needed.
    localparam int TAP0 = 1;
    localparam int TAP1 = -5;
    localparam int TAP2 = 20;

    localparam int ROUND_OFS = 16;
    localparam int SHIFT     = 5;

    localparam int FIR_LATENCY = 3;

    localparam int WIN_TAPS = 6;
    localparam logic [2:0] FILL_FULL = 3'd6;

    // Width helpers relative to the pixel width.
    localparam int DATAWIDTH_DEF = 8;
    localparam int OUT_EXTRA     = 2;
    localparam int SUM_EXTRA     = 7;
    localparam int OUTWIDTH_DEF  = DATAWIDTH_DEF + OUT_EXTRA;
    localparam int SUMWIDTH_DEF  = DATAWIDTH_DEF + SUM_EXTRA;

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_READY   = 2'd2
    } fill_state_e;

    function automatic fill_state_e fill_state(input logic [2:0] count);
        if (count == 3'd0) begin
            return FILL_EMPTY;
        end else if (count == FILL_FULL) begin
            return FILL_READY;
        end
        return FILL_PARTIAL;
    endfunction

endpackage

// File: rtl/fir6_window.sv
// Six-sample pixel window with row fill counter; v0 flags a window holding six samples of one row.
module fir6_window
    import fme_fir_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic                 in_sol,
    input  logic [DATAWIDTH-1:0] in,
    output logic [DATAWIDTH-1:0] w0,
    output logic [DATAWIDTH-1:0] w1,
    output logic [DATAWIDTH-1:0] w2,
    output logic [DATAWIDTH-1:0] w3,
    output logic [DATAWIDTH-1:0] w4,
    output logic [DATAWIDTH-1:0] w5,
    output logic                 v0
);

    logic [DATAWIDTH-1:0] win_q     [WIN_TAPS];
    logic [DATAWIDTH-1:0] win_d     [WIN_TAPS];
    logic [DATAWIDTH-1:0] shifted_w [WIN_TAPS];
    logic [2:0]           count_q;
    logic [2:0]           count_d;
    logic                 v0_q;
    logic                 v0_d;
    logic                 accept;

    assign accept = enable && in_valid;

    // Index 0 is the oldest sample, index WIN_TAPS-1 the newest.
    generate
        for (genvar gi = 0; gi < WIN_TAPS - 1; gi++) begin : g_shift
            assign shifted_w[gi] = win_q[gi+1];
        end
    endgenerate
    assign shifted_w[WIN_TAPS-1] = in;

    generate
        for (genvar gi = 0; gi < WIN_TAPS; gi++) begin : g_win_next
            assign win_d[gi] = accept ? shifted_w[gi] : win_q[gi];
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        v0_d    = 1'b0;
        if (accept) begin
            if (in_sol) begin
                count_d = 3'd1;
            end else if (fill_state(count_q) == FILL_READY) begin
                count_d = FILL_FULL;
            end else begin
                count_d = count_q + 3'd1;
            end
            v0_d = (fill_state(count_d) == FILL_READY);
        end
    end

    generate
        for (genvar gi = 0; gi < WIN_TAPS; gi++) begin : g_win_reg
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    win_q[gi] <= '0;
                end else if (enable) begin
                    win_q[gi] <= win_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 3'd0;
            v0_q    <= 1'b0;
        end else if (enable) begin
            count_q <= count_d;
            v0_q    <= v0_d;
        end
    end

    assign w0 = win_q[0];
    assign w1 = win_q[1];
    assign w2 = win_q[2];
    assign w3 = win_q[3];
    assign w4 = win_q[4];
    assign w5 = win_q[5];
    assign v0 = v0_q;

endmodule

// File: rtl/hpel_fir6.sv
// Streaming H.264 half-pel 6-tap filter: window, pre-add, weighted sum, round/shift (3 stages).
// Define FME_FIR_FULLPREC_EN to add out_raw, the unrounded sum aligned with out_valid.
module hpel_fir6
    import fme_fir_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int OUTWIDTH  = DATAWIDTH + OUT_EXTRA,
    parameter int SUMWIDTH  = DATAWIDTH + SUM_EXTRA
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic                       in_sol,
    input  logic [DATAWIDTH-1:0]       in,
    output logic                       out_valid,
    output logic signed [OUTWIDTH-1:0] out
`ifdef FME_FIR_FULLPREC_EN
    ,
    output logic signed [SUMWIDTH-1:0] out_raw
`endif
);

    localparam logic signed [SUMWIDTH-1:0] K0  = SUMWIDTH'(TAP0);
    localparam logic signed [SUMWIDTH-1:0] K1  = SUMWIDTH'(TAP1);
    localparam logic signed [SUMWIDTH-1:0] K2  = SUMWIDTH'(TAP2);
    localparam logic signed [SUMWIDTH-1:0] RND = SUMWIDTH'(ROUND_OFS);
    localparam int PAD = SUMWIDTH - DATAWIDTH - 1;

    logic [DATAWIDTH-1:0] w0, w1, w2, w3, w4, w5;
    logic                 v0;

    fir6_window #(
        .DATAWIDTH (DATAWIDTH)
    ) u_window (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .in_valid (in_valid),
        .in_sol   (in_sol),
        .in       (in),
        .w0       (w0),
        .w1       (w1),
        .w2       (w2),
        .w3       (w3),
        .w4       (w4),
        .w5       (w5),
        .v0       (v0)
    );

    // S1: symmetric pre-add
    logic [DATAWIDTH:0] a_q, a_d;
    logic [DATAWIDTH:0] b_q, b_d;
    logic [DATAWIDTH:0] c_q, c_d;
    logic               v1_q;

    assign a_d = {1'b0, w0} + {1'b0, w5};
    assign b_d = {1'b0, w1} + {1'b0, w4};
    assign c_d = {1'b0, w2} + {1'b0, w3};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            v1_q <= 1'b0;
        end else if (enable) begin
            a_q  <= a_d;
            b_q  <= b_d;
            c_q  <= c_d;
            v1_q <= v0;
        end
    end

    // S2: weighted sum; the value range cannot overflow SUMWIDTH
    logic signed [SUMWIDTH-1:0] a_s, b_s, c_s;
    logic signed [SUMWIDTH-1:0] sum_q, sum_d;
    logic                       v2_q;

    assign a_s   = {{PAD{1'b0}}, a_q};
    assign b_s   = {{PAD{1'b0}}, b_q};
    assign c_s   = {{PAD{1'b0}}, c_q};
    assign sum_d = K0 * a_s + K1 * b_s + K2 * c_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            v2_q  <= 1'b0;
        end else if (enable) begin
            sum_q <= sum_d;
            v2_q  <= v1_q;
        end
    end

    // S3: round and arithmetic shift; out keeps its last value across bubbles
    logic signed [SUMWIDTH-1:0] rnd_s;
    logic signed [OUTWIDTH-1:0] out_q, out_d;
    logic                       out_valid_q;

    assign rnd_s = sum_q + RND;
    assign out_d = OUTWIDTH'(rnd_s >>> SHIFT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (enable) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_q <= out_d;
            end
        end
    end

`ifdef FME_FIR_FULLPREC_EN
    logic signed [SUMWIDTH-1:0] raw_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            raw_q <= '0;
        end else if (enable && v2_q) begin
            raw_q <= sum_q;
        end
    end

    assign out_raw = raw_q;
`endif

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hpel_fir6.sv
// Self-checking bench for hpel_fir6: directed rows plus randomized traffic against a row-based reference.
module tb_hpel_fir6;
    import fme_fir_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              in_valid;
    logic              in_sol;
    logic [7:0]        in_px;
    logic              out_valid;
    logic signed [9:0] out_val;
`ifdef FME_FIR_FULLPREC_EN
    logic signed [14:0] out_raw;
`endif

    hpel_fir6 #(
        .DATAWIDTH (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_sol    (in_sol),
        .in        (in_px),
        .out_valid (out_valid),
        .out       (out_val)
`ifdef FME_FIR_FULLPREC_EN
        ,
        .out_raw   (out_raw)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int due;
        int val;
        int raw;
    } res_t;

    int   checks   = 0;
    int   failures = 0;
    res_t pend[$];
    int   row[$];
    int   edge_n   = 0;
    logic exp_valid = 1'b0;
    int   exp_out  = 0;
    int   exp_raw  = 0;
    int   n_seen   = 0;
    int   last_out = 0;
    int   last_raw = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the reference on the edge, compare just after it.
    task automatic cyc(input logic en, input logic vld, input logic sol, input logic [7:0] px);
        int   s;
        res_t r;
        enable   = en;
        in_valid = vld;
        in_sol   = sol;
        in_px    = px;
        @(posedge clock);
        #1;
        if (en) begin
            edge_n++;
            if (vld) begin
                if (sol) row.delete();
                row.push_back(int'(px));
                if (row.size() > 6) void'(row.pop_front());
                if (row.size() == 6) begin
                    s = row[0] - 5 * row[1] + 20 * row[2] + 20 * row[3] - 5 * row[4] + row[5];
                    pend.push_back('{edge_n + FIR_LATENCY, (s + 16) >>> 5, s});
                end
            end
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                r         = pend.pop_front();
                exp_valid = 1'b1;
                exp_out   = r.val;
                exp_raw   = r.raw;
            end else begin
                exp_valid = 1'b0;
            end
        end
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        chk("out", out_val, exp_out);
`ifdef FME_FIR_FULLPREC_EN
        chk("out_raw", out_raw, exp_raw);
`endif
        if (en && out_valid === 1'b1) begin
            n_seen++;
            last_out = int'(out_val);
`ifdef FME_FIR_FULLPREC_EN
            last_raw = int'(out_raw);
`endif
        end
        $display("cyc t=%0t en=%0b vld=%0b sol=%0b in=%0d -> out_valid=%0b out=%0d", $time, en, vld, sol, px, out_valid, out_val);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic row6(input int p0, input int p1, input int p2, input int p3, input int p4, input int p5);
        cyc(1'b1, 1'b1, 1'b1, 8'(p0));
        cyc(1'b1, 1'b1, 1'b0, 8'(p1));
        cyc(1'b1, 1'b1, 1'b0, 8'(p2));
        cyc(1'b1, 1'b1, 1'b0, 8'(p3));
        cyc(1'b1, 1'b1, 1'b0, 8'(p4));
        cyc(1'b1, 1'b1, 1'b0, 8'(p5));
    endtask

    // Assert reset between edges, check the immediate clear, then release after one edge.
    task automatic reset_mid;
        #2;
        reset = 1'b1;
        #1;
        pend.delete();
        row.delete();
        exp_valid = 1'b0;
        exp_out   = 0;
        exp_raw   = 0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'sd0);
        chk("rst_out", out_val, 32'sd0);
`ifdef FME_FIR_FULLPREC_EN
        chk("rst_out_raw", out_raw, 32'sd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        $display("reset asserted mid-cycle t=%0t", $time);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_sol   = 1'b0;
        in_px    = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'sd0);
        chk("reset_out", out_val, 32'sd0);
        reset = 1'b0;

        // Flat row of 8 -> 3 results of 100
        n_seen = 0;
        cyc(1'b1, 1'b1, 1'b1, 8'd100);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 8'd100);
        idle(4);
        chk("flat_count", n_seen, 3);
        chk("flat_value", last_out, 100);

        // Step window
        row6(0, 0, 255, 255, 0, 0);
        idle(4);
        chk("step_out", last_out, 319);
`ifdef FME_FIR_FULLPREC_EN
        chk("step_raw", last_raw, 10200);
`endif

        // Negative window
        row6(255, 255, 0, 0, 255, 255);
        idle(4);
        chk("neg_out", last_out, -64);

        // Restart after 3 samples
        n_seen = 0;
        cyc(1'b1, 1'b1, 1'b1, 8'd7);
        cyc(1'b1, 1'b1, 1'b0, 8'd9);
        cyc(1'b1, 1'b1, 1'b0, 8'd11);
        row6(50, 50, 50, 50, 50, 50);
        idle(4);
        chk("restart_count", n_seen, 1);
        chk("restart_value", last_out, 50);

        // Stall with S1-S3 full
        cyc(1'b1, 1'b1, 1'b1, 8'd30);
        for (int i = 1; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 8'(30 + 13 * i));
        cyc(1'b0, 1'b1, 1'b0, 8'd250);
        cyc(1'b0, 1'b1, 1'b1, 8'd5);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 8'(200 - 40 * i));
        idle(4);

        // Reset mid-row: first result needs 6 new samples
        cyc(1'b1, 1'b1, 1'b1, 8'd10);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 8'(20 + i));
        reset_mid();
        n_seen = 0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 8'(60 + 10 * i));
        idle(3);
        chk("post_reset_none", n_seen, 0);
        cyc(1'b1, 1'b1, 1'b0, 8'd120);
        idle(4);
        chk("post_reset_one", n_seen, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 5) != 0, ($urandom % 4) != 0, ($urandom % 12) == 0, 8'($urandom));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
